// File: rtl/wb_bus16to8.sv
// Wishbone 16-to-8 width converter: splits one byte-selected 16-bit access into
// up to two byte cycles, reassembles read data and returns a single ack.
module wb_bus16to8 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        sys_rst,
  input  logic [19:1] wbs_adr_i,
  input  logic [15:0] wbs_dat_i,
  output logic [15:0] wbs_dat_o,
  input  logic [1:0]  wbs_sel_i,
  input  logic        wbs_tga_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  output logic        wbs_ack_o,
  output logic [19:0] wbm_adr_o,
  output logic [7:0]  wbm_dat_o,
  input  logic [7:0]  wbm_dat_i,
  output logic        wbm_tga_o,
  output logic        wbm_we_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, LO, GAP, HI, DONE} state_e;

  typedef struct packed {
    logic [19:1] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
  } req_t;

  state_e        state_q, state_d;
  req_t          req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   rdat_q, rdat_d;
  logic          ack_q, ack_d;
  logic [19:0]   madr_q, madr_d;
  logic [7:0]    mdat_q, mdat_d;
  logic          tga_q, tga_d, we_q, we_d, stb_q, stb_d;
  logic          tmo;

  // Expires on the last allowed wait cycle; a same-cycle ack still takes priority.
  if (TIMEOUT > 0) begin : g_tmo
    assign tmo = stb_q && !wbm_ack_i && (cnt_q == CW'(TIMEOUT - 1));
  end else begin : g_no_tmo
    assign tmo = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    madr_d  = madr_q;
    mdat_d  = mdat_q;
    tga_d   = tga_q;
    we_d    = we_q;
    stb_d   = stb_q;
    unique case (state_q)
      IDLE: begin
        if (wbs_stb_i && wbs_cyc_i) begin
          req_d  = '{adr: wbs_adr_i, dat: wbs_dat_i, sel: wbs_sel_i};
          we_d   = wbs_we_i;
          tga_d  = wbs_tga_i;
          rdat_d = 16'h0000;
          cnt_d  = '0;
          if (wbs_sel_i[0]) begin
            state_d = LO;
            madr_d  = {wbs_adr_i, 1'b0};
            mdat_d  = wbs_dat_i[7:0];
            stb_d   = 1'b1;
          end else if (wbs_sel_i[1]) begin
            state_d = HI;
            madr_d  = {wbs_adr_i, 1'b1};
            mdat_d  = wbs_dat_i[15:8];
            stb_d   = 1'b1;
          end else begin
            state_d = DONE;
            ack_d   = 1'b1;
          end
        end
      end
      LO, HI: begin
        if (!wbs_cyc_i) begin
          stb_d   = 1'b0;
          state_d = IDLE;
        end else if (wbm_ack_i || tmo) begin
          stb_d = 1'b0;
          if (!we_q) begin
            if (state_q == LO) rdat_d[7:0]  = wbm_ack_i ? wbm_dat_i : 8'hFF;
            else               rdat_d[15:8] = wbm_ack_i ? wbm_dat_i : 8'hFF;
          end
          if (state_q == LO && req_q.sel[1] && wbm_ack_i) begin
            state_d = GAP;
          end else begin
            state_d = DONE;
            ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else begin
          state_d = HI;
          madr_d  = {req_q.adr, 1'b1};
          mdat_d  = req_q.dat[15:8];
          stb_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      madr_q  <= '0;
      mdat_q  <= '0;
      tga_q   <= 1'b0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      madr_q  <= madr_d;
      mdat_q  <= mdat_d;
      tga_q   <= tga_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
    end
  end

  assign wbs_dat_o = rdat_q;
  assign wbs_ack_o = ack_q;
  assign wbm_adr_o = madr_q;
  assign wbm_dat_o = mdat_q;
  assign wbm_tga_o = tga_q;
  assign wbm_we_o  = we_q;
  assign wbm_stb_o = stb_q;
  assign wbm_cyc_o = stb_q;
endmodule

// File: tb/tb_wb_bus16to8.sv
// Randomized + directed bench for wb_bus16to8 against a phase-level timing/data model.
module tb_wb_bus16to8;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [19:1] wbs_adr_i;
  logic [15:0] wbs_dat_i, wbs_dat_o;
  logic [1:0]  wbs_sel_i;
  logic        wbs_tga_i, wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_ack_o;
  logic [19:0] wbm_adr_o;
  logic [7:0]  wbm_dat_o, wbm_dat_i;
  logic        wbm_tga_o, wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_bus16to8 #(.TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .sys_rst(sys_rst),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
    .wbs_sel_i(wbs_sel_i), .wbs_tga_i(wbs_tga_i), .wbs_stb_i(wbs_stb_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i), .wbs_ack_o(wbs_ack_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_tga_o(wbm_tga_o), .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One upstream request; the slave acks after w0/w1 wait states in the first/second
  // phase issued and returns rd16's byte for the addressed lane.
  // abort_at > 0 drops cyc at that cycle (after accept) and checks no ack follows.
  task automatic txn(input logic [18:0] adr, input logic [15:0] dat, input logic [1:0] sel,
                     input logic we, input logic tga, input int w0, input int w1,
                     input logic [15:0] rd16, input int abort_at);
    int   lanes[$];
    int   exp_start[$];
    int   exp_len[$];
    int   w[2];
    logic [15:0] exp_rd;
    logic [19:0] exp_adr;
    logic [7:0]  exp_dat;
    int   t, d, ack_exp, ack_c, p, wcnt, len;
    bit   timed, prev;

    w[0] = w0; w[1] = w1;
    if (sel[0]) lanes.push_back(0);
    if (sel[1]) lanes.push_back(1);
    exp_rd = 16'h0000; t = 1; timed = 0;
    for (int i = 0; i < lanes.size(); i++) begin
      if (!timed) begin
        d = (w[i] + 1 <= TO) ? w[i] + 1 : TO;
        exp_start.push_back(t);
        exp_len.push_back(d);
        if (!we) exp_rd[8*lanes[i] +: 8] = (w[i] + 1 <= TO) ? rd16[8*lanes[i] +: 8] : 8'hFF;
        if (w[i] + 1 > TO) timed = 1;
        t += d + 1;
      end
    end
    ack_exp = (exp_start.size() == 0) ? 1 : exp_start[$] + exp_len[$];

    @(negedge clk);
    check("idle_noack", {31'd0, wbs_ack_o}, 32'd0);
    check("idle_nostb", {31'd0, wbm_stb_o}, 32'd0);
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we; wbs_tga_i = tga;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbm_ack_i = 1'b0;
    p = -1; prev = 0; ack_c = 0; wcnt = 0; len = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      check("cyc_eq_stb", {31'd0, wbm_cyc_o}, {31'd0, wbm_stb_o});
      if (wbm_stb_o) begin
        if (!prev) begin
          p++; wcnt = 0; len = 0;
          if (p < exp_start.size()) check("phase_start", c, exp_start[p]);
          else                      check("extra_phase", p, exp_start.size());
        end
        if (p < exp_start.size()) begin
          exp_adr = {adr, lanes[p][0]};
          exp_dat = lanes[p][0] ? dat[15:8] : dat[7:0];
          check("m_adr", {12'd0, wbm_adr_o}, {12'd0, exp_adr});
          check("m_dat", {24'd0, wbm_dat_o}, {24'd0, exp_dat});
          check("m_we_tga", {30'd0, wbm_we_o, wbm_tga_o}, {30'd0, we, tga});
        end
        len++;
        if (wcnt == w[(p > 1) ? 1 : p]) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = wbm_adr_o[0] ? rd16[15:8] : rd16[7:0];
        end else begin
          wbm_ack_i = 1'b0;
          wbm_dat_i = 8'($urandom);
          wcnt++;
        end
      end else begin
        wbm_ack_i = 1'b0;
        if (prev && p >= 0 && p < exp_len.size()) check("phase_len", len, exp_len[p]);
      end
      prev = wbm_stb_o;
      if (abort_at == c) begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        wbm_ack_i = 1'b1; wbm_dat_i = 8'hEE;
        @(negedge clk);
        check("abort_stb", {31'd0, wbm_stb_o}, 32'd0);
        wbm_ack_i = 1'b0;
        repeat (3) begin
          check("abort_noack", {31'd0, wbs_ack_o}, 32'd0);
          @(negedge clk);
        end
        return;
      end
      if (wbs_ack_o) begin
        ack_c = c;
        break;
      end
    end
    check("ack_cycle", ack_c, ack_exp);
    check("rdata", {16'd0, wbs_dat_o}, {16'd0, exp_rd});
    check("nphases", p + 1, exp_start.size());
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbm_ack_i = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0; wbs_tga_i = 1'b0;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbm_dat_i = '0; wbm_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctl", {27'd0, wbm_stb_o, wbm_cyc_o, wbs_ack_o, wbm_we_o, wbm_tga_o}, 32'd0);
    check("rst_madr", {12'd0, wbm_adr_o}, 32'd0);
    check("rst_mdat_sdat", {8'd0, wbm_dat_o, wbs_dat_o}, 32'd0);
    sys_rst = 1'b0;
    idle_cycle();

    // word read, zero-wait
    txn(19'h00010, 16'h0000, 2'b11, 1'b0, 1'b0, 0, 0, 16'h1234, 0);
    // high-byte write
    txn(19'h00123, 16'hABCD, 2'b10, 1'b1, 1'b1, 0, 0, 16'h0000, 0);
    // word read, 3 wait states per phase
    txn(19'h00200, 16'h0000, 2'b11, 1'b0, 1'b0, 3, 3, 16'h5A6B, 0);
    // dead slave: LO times out, HI skipped
    txn(19'h00300, 16'h0000, 2'b11, 1'b0, 1'b0, 100, 100, 16'h9988, 0);
    // ack on the last allowed cycle wins
    txn(19'h00301, 16'h0000, 2'b11, 1'b0, 1'b0, 3, 3, 16'hC3D4, 0);
    // no lanes selected
    txn(19'h00400, 16'h1111, 2'b00, 1'b0, 1'b0, 0, 0, 16'hFFFF, 0);
    // high-byte read timeout
    txn(19'h00401, 16'h0000, 2'b10, 1'b0, 1'b1, 100, 0, 16'h7700, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      txn(19'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 16'($urandom), 0);
    end

    // upstream abort while waiting in HI, with a simultaneous slave ack
    txn(19'h00500, 16'h0000, 2'b11, 1'b0, 1'b0, 0, 10, 16'h4321, 4);
    txn(19'h00501, 16'h0000, 2'b11, 1'b0, 1'b0, 1, 0, 16'h8765, 0);

    // asynchronous reset during LO
    idle_cycle();
    @(negedge clk);
    wbs_adr_i = 19'h12345; wbs_sel_i = 2'b11; wbs_we_i = 1'b1; wbs_tga_i = 1'b1;
    wbs_dat_i = 16'hBEEF; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    @(negedge clk);
    check("pre_rst_stb", {31'd0, wbm_stb_o}, 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    check("rst_async_ctl", {27'd0, wbm_stb_o, wbm_cyc_o, wbs_ack_o, wbm_we_o, wbm_tga_o}, 32'd0);
    check("rst_async_madr", {12'd0, wbm_adr_o}, 32'd0);
    check("rst_async_mdat", {8'd0, wbm_dat_o, wbs_dat_o}, 32'd0);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(negedge clk);
    sys_rst = 1'b0;
    txn(19'h00010, 16'h0000, 2'b11, 1'b0, 1'b0, 0, 1, 16'h1234, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
